// File: rtl/hilo_mdu_if.sv
// Request/flush/read bundle between the execute/commit stages and the HI/LO multiply-divide unit.
// The master side issues operations and reads HI/LO; the slave side is the unit itself.
interface hilo_mdu_if;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        req_ready;
   logic        busy;
   logic        cancel;
   logic [1:0]  hiloren;
   logic [31:0] hilo_rdata;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output req_valid, req_op, req_a, req_b, cancel, hiloren,
      input  req_ready, busy, hilo_rdata, hi, lo
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, cancel, hiloren,
      output req_ready, busy, hilo_rdata, hi, lo
   );
endinterface

// File: rtl/hilo_mdu.sv
// MIPS HI/LO register file with a single-cycle multiplier and a 32-iteration restoring divider.
// A commit-stage flush aborts any in-flight operation without touching HI/LO.
module hilo_mdu (
   input logic       clk,
   input logic       resetn,
   hilo_mdu_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV
   } state_t;

   state_t      state;
   logic        ready_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        mul_signed;

   logic [31:0] quo;
   logic [32:0] rem;
   logic [31:0] dvsr;
   logic        neg_q;
   logic        neg_r;
   logic        div_zero;
   logic [5:0]  cnt;

   logic        accept;
   logic        req_signed;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] product;
   logic [33:0] shifted;
   logic [33:0] diff;
   logic        fits;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign accept     = bus.req_valid && ready_q && !bus.cancel;
   assign req_signed = !bus.req_op[0];

   always_comb begin
      a_mag = (req_signed && bus.req_a[31]) ? -bus.req_a : bus.req_a;
      b_mag = (req_signed && bus.req_b[31]) ? -bus.req_b : bus.req_b;
   end

   // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
   always_comb begin
      ext_a   = mul_signed ? {{32{op_a[31]}}, op_a} : {32'h0, op_a};
      ext_b   = mul_signed ? {{32{op_b[31]}}, op_b} : {32'h0, op_b};
      product = ext_a * ext_b;
   end

   // One restoring step: shift the next dividend bit in, subtract if the divisor fits.
   always_comb begin
      shifted = {rem, quo[31]};
      diff    = shifted - {2'b00, dvsr};
      fits    = !diff[33];
      quo_fix = neg_q ? -quo : quo;
      rem_fix = neg_r ? -rem[31:0] : rem[31:0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         ready_q    <= 1'b1;
         hi_q       <= '0;
         lo_q       <= '0;
         op_a       <= '0;
         op_b       <= '0;
         mul_signed <= 1'b0;
         quo        <= '0;
         rem        <= '0;
         dvsr       <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         div_zero   <= 1'b0;
         cnt        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (bus.req_op)
                     3'b100: hi_q <= bus.req_a;
                     3'b101: lo_q <= bus.req_a;
                     3'b000, 3'b001: begin
                        op_a       <= bus.req_a;
                        op_b       <= bus.req_b;
                        mul_signed <= req_signed;
                        state      <= S_MUL;
                        ready_q    <= 1'b0;
                     end
                     3'b010, 3'b011: begin
                        op_a     <= bus.req_a;
                        quo      <= a_mag;
                        dvsr     <= b_mag;
                        rem      <= '0;
                        neg_q    <= req_signed && (bus.req_a[31] ^ bus.req_b[31]);
                        neg_r    <= req_signed && bus.req_a[31];
                        div_zero <= (bus.req_b == 32'h0);
                        cnt      <= '0;
                        state    <= S_DIV;
                        ready_q  <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end

            S_MUL: begin
               if (!bus.cancel) begin
                  hi_q <= product[63:32];
                  lo_q <= product[31:0];
               end
               state   <= S_IDLE;
               ready_q <= 1'b1;
            end

            S_DIV: begin
               if (bus.cancel) begin
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
               end else if (cnt == 6'd32) begin
                  // A zero divisor reports all-ones quotient and the raw dividend, unsigned-style.
                  if (div_zero) begin
                     lo_q <= 32'hFFFF_FFFF;
                     hi_q <= op_a;
                  end else begin
                     lo_q <= quo_fix;
                     hi_q <= rem_fix;
                  end
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
               end else begin
                  rem <= fits ? diff[32:0] : shifted[32:0];
                  quo <= {quo[30:0], fits};
                  cnt <= cnt + 6'd1;
               end
            end

            default: begin
               state   <= S_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.busy      = !ready_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;

   always_comb begin
      case (bus.hiloren)
         2'b00:   bus.hilo_rdata = '0;
         2'b01:   bus.hilo_rdata = lo_q;
         default: bus.hilo_rdata = hi_q;
      endcase
   end

endmodule

// File: tb/tb_hilo_mdu.sv
// Randomized bench for hilo_mdu: a cycle-level reference model of HI/LO, busy and read data
// is compared against the unit on every falling edge, plus directed literal checks.
module tb_hilo_mdu;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   hilo_mdu_if bus ();

   hilo_mdu dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int checks = 0;
   int failures = 0;

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [31:0] p_hi = '0;
   logic [31:0] p_lo = '0;
   int          m_left = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result of an operation straight from the MIPS definition.
   function automatic void ref_result(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b,
                                      output logic [31:0] rh, output logic [31:0] rl);
      longint      sa, sb, sp, sq, sr;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      rh = '0;
      rl = '0;
      case (op)
         3'b000: begin
            sp = sa * sb;
            rh = sp[63:32];
            rl = sp[31:0];
         end
         3'b001: begin
            up = {32'h0, a} * {32'h0, b};
            rh = up[63:32];
            rl = up[31:0];
         end
         3'b010: begin
            if (b == 32'h0) begin
               rh = a;
               rl = 32'hFFFF_FFFF;
            end else begin
               sq = sa / sb;
               sr = sa % sb;
               rh = sr[31:0];
               rl = sq[31:0];
            end
         end
         3'b011: begin
            if (b == 32'h0) begin
               rh = a;
               rl = 32'hFFFF_FFFF;
            end else begin
               rh = a % b;
               rl = a / b;
            end
         end
         default: ;
      endcase
   endfunction

   // Timing model: an in-flight op is a countdown of cycles until its result lands.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_hi   = '0;
         m_lo   = '0;
         m_left = 0;
      end else if (m_left > 0) begin
         if (bus.cancel) m_left = 0;
         else if (m_left == 1) begin
            m_hi   = p_hi;
            m_lo   = p_lo;
            m_left = 0;
         end else m_left--;
      end else if (bus.req_valid && !bus.cancel) begin
         case (bus.req_op)
            3'b100: m_hi = bus.req_a;
            3'b101: m_lo = bus.req_a;
            3'b000, 3'b001: begin
               ref_result(bus.req_op, bus.req_a, bus.req_b, p_hi, p_lo);
               m_left = 1;
            end
            3'b010, 3'b011: begin
               ref_result(bus.req_op, bus.req_a, bus.req_b, p_hi, p_lo);
               m_left = 33;
            end
            default: ;
         endcase
      end
   end

   initial begin
      logic [31:0] exp_rd;
      @(posedge clk);
      forever begin
         @(negedge clk);
         check("hi", bus.hi, m_hi);
         check("lo", bus.lo, m_lo);
         check("req_ready", {31'h0, bus.req_ready}, {31'h0, m_left == 0});
         check("busy", {31'h0, bus.busy}, {31'h0, m_left != 0});
         case (bus.hiloren)
            2'b00:   exp_rd = '0;
            2'b01:   exp_rd = m_lo;
            default: exp_rd = m_hi;
         endcase
         check("hilo_rdata", bus.hilo_rdata, exp_rd);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Offers one request (caller guarantees req_ready), then counts busy cycles.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int cancel_cyc, input bit cancel_offer, output int bc);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.cancel    = cancel_offer;
      step();
      bus.req_valid = 1'b0;
      bus.cancel    = 1'b0;
      bus.req_op    = 3'($urandom);
      bus.req_a     = $urandom;
      bus.req_b     = $urandom;
      bc = 0;
      for (int i = 0; i < 100; i++) begin
         if (!bus.busy) break;
         bc++;
         bus.cancel  = (i == cancel_cyc);
         bus.hiloren = 2'($urandom);
         step();
      end
      bus.cancel = 1'b0;
      if (bus.busy) begin
         failures++;
         $display("FAIL busy_timeout actual=busy required=idle within 100 cycles");
      end
   endtask

   function automatic int exp_busy(input logic [2:0] op, input int cc, input bit offer);
      if (offer) return 0;
      if (op == 3'b000 || op == 3'b001) return 1;
      if (op == 3'b010 || op == 3'b011) return (cc >= 0 && cc < 33) ? cc + 1 : 33;
      return 0;
   endfunction

   initial begin
      int          bc;
      logic [2:0]  op;
      logic [31:0] a, b;
      int          cc;
      bit          offer;
      bus.req_valid = 1'b0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.cancel    = 1'b0;
      bus.hiloren   = 2'b00;

      step();
      step();
      check("reset_hi", bus.hi, 32'h0);
      check("reset_lo", bus.lo, 32'h0);
      check("reset_ready", {31'h0, bus.req_ready}, 32'h1);
      check("reset_busy", {31'h0, bus.busy}, 32'h0);
      check("reset_rdata", bus.hilo_rdata, 32'h0);
      resetn = 1'b1;
      step();

      issue(3'b000, 32'hFFFF_FFFF, 32'h2, -1, 1'b0, bc);
      check("mult_busy", 32'(bc), 32'd1);
      check("mult_hi", bus.hi, 32'hFFFF_FFFF);
      check("mult_lo", bus.lo, 32'hFFFF_FFFE);
      issue(3'b001, 32'hFFFF_FFFF, 32'h2, -1, 1'b0, bc);
      check("multu_hi", bus.hi, 32'h1);
      check("multu_lo", bus.lo, 32'hFFFF_FFFE);

      issue(3'b010, 32'hFFFF_FFF9, 32'h2, -1, 1'b0, bc);
      check("div_busy", 32'(bc), 32'd33);
      check("div_lo", bus.lo, 32'hFFFF_FFFD);
      check("div_hi", bus.hi, 32'hFFFF_FFFF);
      issue(3'b011, 32'd100, 32'd7, -1, 1'b0, bc);
      check("divu_lo", bus.lo, 32'd14);
      check("divu_hi", bus.hi, 32'd2);
      issue(3'b011, 32'd100, 32'd0, -1, 1'b0, bc);
      check("divu0_lo", bus.lo, 32'hFFFF_FFFF);
      check("divu0_hi", bus.hi, 32'd100);
      issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, bc);
      check("divovf_lo", bus.lo, 32'h8000_0000);
      check("divovf_hi", bus.hi, 32'h0);

      issue(3'b011, 32'd100, 32'd7, 10, 1'b0, bc);
      check("cancel_busy", 32'(bc), 32'd11);
      check("cancel_hi", bus.hi, 32'h0);
      check("cancel_lo", bus.lo, 32'h8000_0000);
      check("cancel_ready", {31'h0, bus.req_ready}, 32'h1);
      issue(3'b011, 32'd9, 32'd3, -1, 1'b0, bc);
      check("divu93_lo", bus.lo, 32'd3);
      check("divu93_hi", bus.hi, 32'd0);

      issue(3'b011, 32'd50, 32'd5, 32, 1'b0, bc);
      check("late_cancel_busy", 32'(bc), 32'd33);
      check("late_cancel_lo", bus.lo, 32'd3);

      issue(3'b100, 32'h1234_5678, 32'h0, -1, 1'b0, bc);
      check("mthi_busy", 32'(bc), 32'd0);
      bus.hiloren = 2'b10;
      #1;
      check("mfhi_rdata", bus.hilo_rdata, 32'h1234_5678);
      issue(3'b101, 32'hDEAD_BEEF, 32'h0, -1, 1'b1, bc);
      check("mtlo_cancel_lo", bus.lo, 32'd3);

      issue(3'b101, 32'hA5A5_0001, 32'h0, -1, 1'b0, bc);
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b010;
      bus.req_a     = 32'd1000;
      bus.req_b     = 32'd3;
      step();
      bus.req_valid = 1'b0;
      repeat (21) step();
      resetn = 1'b0;
      #1;
      check("rst_mid_hi", bus.hi, 32'h0);
      check("rst_mid_lo", bus.lo, 32'h0);
      check("rst_mid_ready", {31'h0, bus.req_ready}, 32'h1);
      check("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
      step();
      resetn = 1'b1;
      step();

      for (int n = 0; n < 200; n++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 9))
            0: b = 32'h0;
            1: b = 32'hFFFF_FFFF;
            2: a = 32'h8000_0000;
            3: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         cc    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 34)) : -1;
         offer = ($urandom_range(0, 7) == 0);
         issue(op, a, b, cc, offer, bc);
         check("rand_busy", 32'(bc), 32'(exp_busy(op, cc, offer)));
         repeat ($urandom_range(0, 2)) begin
            bus.hiloren = 2'($urandom);
            step();
         end
      end

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Multiply/divide unit and HI/LO register file for the MIPS pipeline. Sits beside the execute stage, directly upstream of the exception-commit stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from execute.
- Runs multiply in 1 cycle and divide as a 32-iteration restoring divider.
- Holds the architectural HI/LO and supplies the MFHI/MFLO read data consumed at commit.
- An exception flush from commit cancels any in-flight operation without touching HI/LO.

## Interface
Parameters:
- none (datapath fixed at 32 bits)

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  1  operation request from execute
- req_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved, ignored when accepted
- req_a  in  32  rs operand (dividend / multiplicand / MT source)
- req_b  in  32  rt operand (divisor / multiplier)
- req_ready  out  1  high only in IDLE; request accepted on edge where req_valid && req_ready && !cancel
- busy  out  1  = !req_ready; execute stalls on it
- cancel  in  1  exception/eret flush from commit; aborts current or offered op
- hiloren  in  2  10 MFHI, 01 MFLO, 00 none; 11 returns HI
- hilo_rdata  out  32  combinational read of architectural HI/LO per hiloren; 0 when hiloren=00
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
States:
- IDLE
- MUL
- DIV
- No other states.

IDLE:
- On accept of MTHI/MTLO: write req_a to HI/LO at that edge; stay IDLE.
- On accept of MULT/MULTU: latch operands; go to MUL.
- On accept of DIV/DIVU:
  - Latch |a|, |b| (signed) or raw (unsigned), sign flags, and a 6-bit counter = 0.
  - Go to DIV.
- Reserved op: no effect.

MUL:
- Form the 64-bit product of the latched operands: signed for MULT, unsigned for MULTU.
- Write HI = product[63:32], LO = product[31:0].
- Return to IDLE.

DIV: restoring division, one quotient bit per cycle.
- Remainder register is 33 bits, so the 0x80000000 magnitude is exact.
- Counter counts 0..31; the next edge after counter == 31 performs the write.
- Signed result: quotient negated if sign(a) ^ sign(b); remainder takes the sign of a.
- Divisor zero, both signed and unsigned: LO = 0xFFFFFFFF, HI = req_a as latched; no sign fix.
- 0x80000000 / -1 (signed): LO = 0x80000000, HI = 0.

cancel:
- In MUL or DIV: next edge returns to IDLE, no HI/LO write.
- In IDLE: the offered request is dropped, including MTHI/MTLO.

Ordering:
- hilo_rdata reads registers only; there is no bypass.
- The pipeline guarantees that MFHI/MFLO reaching commit are older than any op in flight.

## Timing
- Reset (async, resetn low): state IDLE, HI = 0, LO = 0, counter = 0, req_ready = 1, busy = 0, hilo_rdata = 0 when hiloren = 00.
- Edge 0 is the accept edge.
- MTHI/MTLO: HI/LO visible in the cycle after edge 0; busy never asserts.
- MULT/MULTU: busy high for exactly 1 cycle; HI/LO updated at edge 1; req_ready high after edge 1.
- DIV/DIVU: busy high for exactly 33 cycles (32 iterations plus write edge); HI/LO updated at edge 33; req_ready high after edge 33.
- Back-to-back: a new request may be accepted in the first cycle req_ready is high.
- cancel sampled high in the cycle before the write edge suppresses the write; IDLE follows that edge.
- resetn low mid-operation: immediate IDLE, HI/LO cleared, partial result discarded.

## Test plan
- MULT a=0xFFFFFFFF, b=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE, busy 1 cycle. MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, busy exactly 33 cycles. DIVU 100/7 -> LO=14, HI=2.
- DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=100. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100/7, cancel pulsed in iteration 10 -> HI/LO keep prior values, req_ready=1 next cycle. Then DIVU 9/3 accepted and yields LO=3, HI=0.
- MTHI 0x12345678, then hiloren=10 next cycle -> hilo_rdata=0x12345678. MTLO with cancel high -> LO unchanged.
- resetn dropped at DIV iteration 20 after HI/LO were preloaded nonzero -> HI=LO=0, req_ready=1, busy=0 immediately.
